game_flow_fsm: RTL and testbench
================================

# game_flow_fsm

Top-level game-flow controller that consumes the one-frame `start`/`back` pulses produced by the keyboard command decoder and the `hit` pulse from collision logic. It owns the game state (title, play, pause, game-over), the life counter and the post-hit invulnerability window. Its outputs drive the sprite/collision enables, the HUD life display and the screen selector in the frame-rate domain.

## Interface
- `LIVES_INIT`, 3: lives loaded on new game; legal range 1..3.
- `INVULN_FRAMES`, 60: frames of hit immunity after a life is lost; ≥1.
- `GAMEOVER_FRAMES`, 180: frames the game-over screen holds before returning to title; ≥1.
- `Reset`  in  1  asynchronous, active-high reset.
- `frame_clk`  in  1  clock, one edge per video frame.
- `start`  in  1  single-cycle pulse, space key.
- `back`  in  1  single-cycle pulse, back key.
- `hit`  in  1  single-cycle pulse, player collided this frame.
- `state`  out  2  current game state (`game_state_t`).
- `life`  out  2  remaining lives.
- `play_en`  out  1  high while state is PLAY.
- `invuln`  out  1  high while invulnerability counter is nonzero.
- `clear_field`  out  1  single-cycle pulse on new-game entry to PLAY.

## Operation
- States: TITLE=0, PLAY=1, PAUSE=2, OVER=3. All outputs registered.
- Reset values: state TITLE, life 0, play_en 0, invuln 0, clear_field 0, both counters 0.
- TITLE: `start` → PLAY, life ← LIVES_INIT, invuln counter ← 0, clear_field=1 for that cycle. `back`, `hit` ignored.
- PLAY: `hit` with invuln counter 0 → life −1, invuln counter ← INVULN_FRAMES. If life was 1 → OVER, life ← 0, over counter ← GAMEOVER_FRAMES−1. `hit` with nonzero invuln counter ignored. `back` → TITLE (see Configuration). `start` ignored. Invuln counter decrements by 1 per frame, saturating at 0.
- OVER: over counter decrements per frame; at 0 → TITLE next edge. `back` → TITLE immediately. `start`, `hit` ignored; life holds 0.
- Simultaneous events, priority: hit evaluated first. Hit causing game over wins over `back`. A non-fatal hit plus `back` applies both (life decrements, state leaves PLAY).
- Life is never decremented below 0; no wrap-around.
- Counter widths: `$clog2(max+1)`; no overflow possible by construction.

## Timing
- Inputs sampled on rising `frame_clk`; resulting state/output change is visible after that same edge (zero-frame latency, registered).
- clear_field high exactly one cycle, coincident with the first cycle state = PLAY after TITLE; never asserted on resume from PAUSE.
- Invulnerability: a hit at edge k sets invuln high for cycles k..k+INVULN_FRAMES−1. A second hit is accepted at edge k+INVULN_FRAMES.
- OVER lasts exactly GAMEOVER_FRAMES cycles absent `back`.
- Reset asserted mid-game: all outputs return to reset values asynchronously; first post-reset `start` behaves as from TITLE.

## Configuration
- `GAME_PAUSE_EN` defined: `back` in PLAY → PAUSE. In PAUSE, `start` → PLAY (no clear_field, life kept), `back` → TITLE; both together → TITLE. Invuln counter frozen, `hit` ignored, play_en 0.
- Undefined: PAUSE state unreachable; `back` in PLAY → TITLE directly; state value 2 never produced.

## Structure
- `game_pkg`: `game_state_t` enum (2-bit, values above), `LIFE_W = 2`.
- Sub-module `frame_down_counter` (parameter MAX; load, load value, enable, zero flag; saturates at 0), instantiated twice for the invuln and over counters.

## Test plan
- Reset, then `start` pulse → state PLAY, life 3, clear_field high one cycle, play_en 1.
- In PLAY: `hit`, second `hit` 10 frames later, third `hit` 60 frames after the first → life 2, 2, 1; invuln high exactly 60 cycles after each accepted hit.
- Three accepted hits → state OVER, life 0; stays OVER 180 cycles, then TITLE; `start` during OVER ignored.
- Fatal `hit` and `back` in the same cycle → OVER; non-fatal `hit` and `back` → life decremented and TITLE (PAUSE with `GAME_PAUSE_EN`).
- With `GAME_PAUSE_EN`: `back` in PLAY → PAUSE, invuln value frozen; `start` → PLAY, no clear_field, life unchanged; without the macro, the same stimulus → TITLE.
- Reset asserted mid-PLAY with invuln active → immediate TITLE, life 0, invuln 0.

Source files
------------

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
//
// Shared types and helpers for the game-flow controller.
//
//   game_state_t : 2-bit screen/game state (TITLE, PLAY, PAUSE, OVER)
//   LIFE_W       : width of the life counter shown on the HUD
//   cnt_w()      : width of a down counter able to hold 0..max
// ---------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [1:0] {
        TITLE = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    localparam int LIFE_W = 2;

    // $clog2(max+1), never less than one bit.
    function automatic int cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/game_flow_fsm_frame_down_counter.sv
// ---------------------------------------------------------------------------
// frame_down_counter
//
// Loadable down counter that steps once per frame and saturates at zero.
// The zero flag is kept in its own flop so that outputs derived from it
// (the invulnerability indicator) come straight from a register.
//
// Parameters:
//   MAX       largest value ever loaded; sets the counter width
// Ports:
//   frame_clk in   frame-rate clock
//   Reset     in   asynchronous, active-high reset (count 0, zero 1)
//   load      in   load load_val this frame (wins over en)
//   load_val  in   value to load
//   en        in   decrement this frame (no effect once at zero)
//   count     out  current count
//   zero      out  registered (count == 0)
// ---------------------------------------------------------------------------
module frame_down_counter
    import game_pkg::*;
#(
    parameter int MAX = 60,
    localparam int W  = cnt_w(MAX)
) (
    input  logic         frame_clk,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         zero
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            count <= '0;
            zero  <= 1'b1;
        end else if (load) begin
            count <= load_val;
            zero  <= (load_val == '0);
        end else if (en && !zero) begin
            count <= count - W'(1);
            zero  <= (count == W'(1));
        end
    end

endmodule

// File: rtl/game_flow_fsm.sv
// ---------------------------------------------------------------------------
// game_flow_fsm
//
// Frame-rate game-flow controller. Consumes one-frame start/back pulses from
// the keyboard decoder and the hit pulse from collision logic; owns the game
// state, the life counter and the post-hit invulnerability window.
//
// Build option:
//   GAME_PAUSE_EN  defined   -> back in PLAY enters PAUSE; start resumes.
//                  undefined -> back in PLAY returns to TITLE; PAUSE unused.
//
// Parameters:
//   LIVES_INIT       lives loaded on a new game (1..3)
//   INVULN_FRAMES    frames of hit immunity after losing a life (>=1)
//   GAMEOVER_FRAMES  frames the game-over screen is held (>=1)
// Ports:
//   frame_clk   in   clock, one rising edge per video frame
//   Reset       in   asynchronous, active-high reset
//   start       in   one-frame pulse, space key
//   back        in   one-frame pulse, back key
//   hit         in   one-frame pulse, player collided this frame
//   state       out  current game state (game_state_t)
//   life        out  remaining lives
//   play_en     out  high while state is PLAY
//   invuln      out  high while the invulnerability counter is nonzero
//   clear_field out  one-frame pulse on new-game entry to PLAY
// All outputs are registered.
// ---------------------------------------------------------------------------
module game_flow_fsm
    import game_pkg::*;
#(
    parameter int LIVES_INIT      = 3,
    parameter int INVULN_FRAMES   = 60,
    parameter int GAMEOVER_FRAMES = 180
) (
    input  logic              frame_clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              back,
    input  logic              hit,
    output game_state_t       state,
    output logic [LIFE_W-1:0] life,
    output logic              play_en,
    output logic              invuln,
    output logic              clear_field
);

    localparam int INV_W = cnt_w(INVULN_FRAMES);
    localparam int OVR_W = cnt_w(GAMEOVER_FRAMES);

    logic [INV_W-1:0] inv_count;
    logic             inv_zero;
    logic             inv_load;
    logic [INV_W-1:0] inv_val;
    logic             inv_en;

    logic [OVR_W-1:0] ovr_count;
    logic             ovr_zero;
    logic             ovr_load;
    logic             ovr_en;

    logic             hit_ok;
    logic             fatal;

    // The invulnerability counter is decremented on the same edge a hit is
    // sampled, so a counter sitting at 1 has expired by this frame: a hit at
    // edge k is covered for edges k+1..k+INVULN_FRAMES-1 and accepted again at
    // edge k+INVULN_FRAMES.
    assign hit_ok = (state == PLAY) && hit && (inv_count <= INV_W'(1));
    assign fatal  = hit_ok && (life <= LIFE_W'(1));

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        inv_load = 1'b0;
        inv_val  = '0;
        inv_en   = 1'b1;
        ovr_load = fatal;
        ovr_en   = (state == OVER) && !ovr_zero;

        if (state == TITLE && start) begin
            inv_load = 1'b1;
            inv_val  = '0;
        end
        if (hit_ok) begin
            inv_load = 1'b1;
            inv_val  = INV_W'(INVULN_FRAMES);
        end
`ifdef GAME_PAUSE_EN
        // Invulnerability time does not run while the game is paused.
        if (state == PAUSE) begin
            inv_en = 1'b0;
        end
`endif
    end

    frame_down_counter #(
        .MAX (INVULN_FRAMES)
    ) u_inv_cnt (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .load      (inv_load),
        .load_val  (inv_val),
        .en        (inv_en),
        .count     (inv_count),
        .zero      (inv_zero)
    );

    // Loaded with GAMEOVER_FRAMES-1: the load edge itself is the first OVER
    // frame, and the exit edge is the one that sees the count at zero.
    frame_down_counter #(
        .MAX (GAMEOVER_FRAMES)
    ) u_ovr_cnt (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .load      (ovr_load),
        .load_val  (OVR_W'(GAMEOVER_FRAMES - 1)),
        .en        (ovr_en),
        .count     (ovr_count),
        .zero      (ovr_zero)
    );

    // Taken directly from the counter's zero flop.
    assign invuln = ~inv_zero;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state       <= TITLE;
            life        <= '0;
            play_en     <= 1'b0;
            clear_field <= 1'b0;
        end else begin
            clear_field <= 1'b0;

            case (state)
                TITLE: begin
                    if (start) begin
                        state       <= PLAY;
                        life        <= LIFE_W'(LIVES_INIT);
                        play_en     <= 1'b1;
                        clear_field <= 1'b1;
                    end
                end

                PLAY: begin
                    // A hit is resolved before back; a fatal hit wins outright.
                    if (fatal) begin
                        state   <= OVER;
                        life    <= '0;
                        play_en <= 1'b0;
                    end else begin
                        if (hit_ok) begin
                            life <= life - LIFE_W'(1);
                        end
                        if (back) begin
`ifdef GAME_PAUSE_EN
                            state <= PAUSE;
`else
                            state <= TITLE;
`endif
                            play_en <= 1'b0;
                        end
                    end
                end

                PAUSE: begin
`ifdef GAME_PAUSE_EN
                    // back has priority when both keys arrive together.
                    if (back) begin
                        state <= TITLE;
                    end else if (start) begin
                        state   <= PLAY;
                        play_en <= 1'b1;
                    end
`else
                    // Not reachable in this build; recover to the title screen.
                    state   <= TITLE;
                    play_en <= 1'b0;
`endif
                end

                OVER: begin
                    life <= '0;
                    if (back || ovr_count == '0) begin
                        state <= TITLE;
                    end
                end

                default: begin
                    state   <= TITLE;
                    play_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_fsm.sv
// ---------------------------------------------------------------------------
// tb_game_flow_fsm
//
// Directed bench for game_flow_fsm with default parameters (3 lives,
// 60 invulnerability frames, 180 game-over frames). The driver pushes the
// hand-derived post-edge outputs for every frame into a queue; a monitor
// pops one entry 1 ns after each rising edge and compares. Honors
// GAME_PAUSE_EN for the pause-dependent expectations.
// ---------------------------------------------------------------------------
module tb_game_flow_fsm;
    import game_pkg::*;

    localparam int INV_DC = 2;   // invuln value not checked this frame

    typedef struct {
        game_state_t st;
        logic [1:0]  life;
        logic        pe;
        int          inv;
        logic        cf;
        string       tag;
    } exp_t;

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic        start, back, hit;
    game_state_t state;
    logic [1:0]  life;
    logic        play_en, invuln, clear_field;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    game_flow_fsm dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .start       (start),
        .back        (back),
        .hit         (hit),
        .state       (state),
        .life        (life),
        .play_en     (play_en),
        .invuln      (invuln),
        .clear_field (clear_field)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    // Called at a falling edge: drive inputs, queue expected result of the
    // coming rising edge, advance to the next falling edge.
    task automatic step(input logic s, input logic b, input logic h,
                        input game_state_t st, input logic [1:0] lf,
                        input logic pe, input int inv, input logic cf,
                        input string tag);
        exp_t e;
        start = s;
        back  = b;
        hit   = h;
        e.st = st; e.life = lf; e.pe = pe; e.inv = inv; e.cf = cf; e.tag = tag;
        exp_q.push_back(e);
        @(negedge frame_clk);
    endtask

    task automatic idle(input int n, input game_state_t st, input logic [1:0] lf,
                        input logic pe, input int inv, input string tag);
        for (int i = 0; i < n; i++) step(0, 0, 0, st, lf, pe, inv, 0, tag);
    endtask

    // Monitor: one comparison set per frame that has an expectation queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge frame_clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check({e.tag, ".state"}, int'(state), int'(e.st));
                check({e.tag, ".life"}, int'(life), int'(e.life));
                check({e.tag, ".play_en"}, int'(play_en), int'(e.pe));
                check({e.tag, ".clear_field"}, int'(clear_field), int'(e.cf));
                if (e.inv != INV_DC) check({e.tag, ".invuln"}, int'(invuln), e.inv);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        start = 1'b0; back = 1'b0; hit = 1'b0;
        repeat (2) @(negedge frame_clk);
        check("reset.state", int'(state), int'(TITLE));
        check("reset.life", int'(life), 0);
        check("reset.play_en", int'(play_en), 0);
        check("reset.invuln", int'(invuln), 0);
        check("reset.clear_field", int'(clear_field), 0);
        Reset = 1'b0;

        // Idle title, then a new game; back/hit in TITLE are ignored.
        step(0, 1, 1, TITLE, 0, 0, 0, 0, "title_ignore");
        step(1, 0, 0, PLAY, 3, 1, 0, 1, "start");
        step(0, 0, 0, PLAY, 3, 1, 0, 0, "cf_drop");

        // First hit at edge k; a second hit at k+10 is ignored; the hit at
        // k+60 is accepted.
        step(0, 0, 1, PLAY, 2, 1, 1, 0, "hit1");
        for (int i = 1; i <= 59; i++)
            step(0, 0, (i == 10), PLAY, 2, 1, 1, 0, "inv1");
        step(0, 0, 1, PLAY, 1, 1, 1, 0, "hit2_at60");
        // Window of the second hit: exactly 60 frames high.
        idle(59, PLAY, 1, 1, 1, "inv2");
        idle(1, PLAY, 1, 1, 0, "inv2_end");
        idle(2, PLAY, 1, 1, 0, "inv2_low");

        // Fatal hit -> OVER for exactly 180 frames; start in OVER ignored.
        step(0, 0, 1, OVER, 0, 0, INV_DC, 0, "fatal");
        for (int i = 1; i <= 179; i++)
            step((i == 5), 0, (i == 7), OVER, 0, 0, INV_DC, 0, "over_hold");
        step(0, 0, 0, TITLE, 0, 0, 0, 0, "over_exit");

        // New game, bring life to 1, then fatal hit together with back.
        step(1, 0, 0, PLAY, 3, 1, 0, 1, "start2");
        step(0, 0, 1, PLAY, 2, 1, 1, 0, "g2_hit1");
        idle(59, PLAY, 2, 1, 1, "g2_inv1");
        step(0, 0, 1, PLAY, 1, 1, 1, 0, "g2_hit2");
        idle(60, PLAY, 1, 1, INV_DC, "g2_inv2");
        step(0, 1, 1, OVER, 0, 0, INV_DC, 0, "fatal_back");
        idle(3, OVER, 0, 0, INV_DC, "over2");
        step(0, 1, 0, TITLE, 0, 0, INV_DC, 0, "over_back");

        // Non-fatal hit together with back.
        step(1, 0, 0, PLAY, 3, 1, 0, 1, "start3");
`ifdef GAME_PAUSE_EN
        step(0, 1, 1, PAUSE, 2, 0, 1, 0, "hit_back_pause");
        idle(5, PAUSE, 2, 0, 1, "paused");
        step(0, 0, 1, PAUSE, 2, 0, 1, 0, "pause_hit_ign");
        step(1, 0, 0, PLAY, 2, 1, 1, 0, "resume");
        // Counter was frozen at 60 during pause: 60 more frames to expire.
        idle(59, PLAY, 2, 1, 1, "frozen_inv");
        idle(1, PLAY, 2, 1, 0, "frozen_inv_end");
        step(0, 1, 0, PAUSE, 2, 0, 0, 0, "pause2");
        step(1, 1, 0, TITLE, 2, 0, 0, 0, "pause_both");
`else
        step(0, 1, 1, TITLE, 2, 0, 1, 0, "hit_back_title");
        step(1, 0, 0, PLAY, 3, 1, 0, 1, "restart");
        step(0, 1, 0, TITLE, 3, 0, 0, 0, "back_title");
`endif

        // Reset asserted mid-PLAY with invulnerability active.
        step(1, 0, 0, PLAY, 3, 1, 0, 1, "start4");
        step(0, 0, 1, PLAY, 2, 1, 1, 0, "g4_hit");
        idle(2, PLAY, 2, 1, 1, "g4_inv");
        #2 Reset = 1'b1;
        #1;
        check("async_reset.state", int'(state), int'(TITLE));
        check("async_reset.life", int'(life), 0);
        check("async_reset.play_en", int'(play_en), 0);
        check("async_reset.invuln", int'(invuln), 0);
        check("async_reset.clear_field", int'(clear_field), 0);
        @(negedge frame_clk);
        Reset = 1'b0;
        step(1, 0, 0, PLAY, 3, 1, 0, 1, "post_reset_start");
        step(0, 0, 0, PLAY, 3, 1, 0, 0, "post_reset_idle");

        begin
            int budget = 10;
            while (exp_q.size() != 0 && budget > 0) begin
                @(negedge frame_clk);
                budget--;
            end
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
